sfu_acc_buf: RTL
================

// Module: sfu_acc_buf
// PURPOSE
//  Multi-entry accumulate-and-activate stage at the south edge of the PE array.
//  Accumulates per-column partial sums from the array into a DEPTH-entry
//  buffer, one entry per output position. Drains the entries in order through
//  an optional ReLU stage to the output/SRAM writer using a valid/ready handshake.
// PARAMETERS
//  PSUM_BW  16  signed width of one column psum (input, storage and output)
//  COL      8   number of columns (lanes) handled in parallel
//  DEPTH    16  number of accumulation entries; power of 2, >=2
//  AW       $clog2(DEPTH)  entry address width (derived, do not override)
// PORTS
//  clk        in   1            clock
//  reset      in   1            asynchronous, active-low reset
//  in_valid   in   1            psum_in/in_addr valid this cycle
//  in_first   in   1            with in_valid: load entry (overwrite) instead of add
//  in_addr    in   AW           target entry
//  psum_in    in   COL*PSUM_BW  lane j at [(j+1)*PSUM_BW-1 : j*PSUM_BW], two's complement
//  sat_en     in   1            1 = saturating add, 0 = wrapping add
//  relu_en    in   1            1 = clamp negative outputs to 0 on drain
//  drain      in   1            pulse: start draining entries 0..DEPTH-1
//  out_ready  in   1            downstream accepts psum_out
//  out_valid  out  1            psum_out holds a drained entry
//  psum_out   out  COL*PSUM_BW  drained entry, same lane packing as psum_in
//  out_last   out  1            with out_valid: this is entry DEPTH-1
//  busy       out  1            FSM not IDLE
//  done       out  1            one-cycle pulse after the last handshake
//  err        out  1            sticky: in_valid seen while busy; cleared by reset only
// BEHAVIOUR
//  Reset (async, reset==0): all buffer entries, out_valid, psum_out, out_last, busy,
//   done, err -> 0; FSM -> IDLE; read pointer -> 0.
//  FSM: IDLE -(drain)-> DRAIN -(handshake on entry DEPTH-1)-> DONE -> IDLE
//   (DONE lasts exactly 1 cycle; done=1 only in DONE). busy=1 in DRAIN and DONE.
//  Accumulate (IDLE only), in_valid at edge T: per lane,
//   buf[a][j] <= in_first ? psum_in[j] : add(buf[a][j], psum_in[j]); visible from T+1.
//   Single write port; no internal forwarding is needed because the next write
//   to the same addr reads the updated value.
//  add(): PSUM_BW+1-bit signed sum; with sat_en=1, clamp to +2^(PSUM_BW-1)-1 or
//   -2^(PSUM_BW-1); with sat_en=0, keep the low PSUM_BW bits.
//   Lanes are independent; there is no carry between lanes.
//  in_valid while busy: write dropped, err<=1.
//  drain in IDLE with in_valid in the same cycle: the write commits first, then
//   the drain starts.
//  drain while busy: ignored.
//  Drain: in DRAIN, the output register loads buf[rd_ptr] when (!out_valid || out_ready).
//   rd_ptr then increments. ReLU is applied at load: lane<0 && relu_en -> 0.
//   out_last = (loaded entry index == DEPTH-1).
//   Latency: drain sampled at T -> out_valid=1 at T+2 showing entry 0.
//   With out_ready held at 1: one entry per cycle, DEPTH back-to-back beats.
//  Handshake: beat transfers when out_valid && out_ready. While out_valid=1 and
//   out_ready=0, psum_out and out_last hold stable. out_valid drops only after
//   the handshake, when no new load occurs.
//  After the last beat: out_valid=0 and the FSM goes to DONE.
//   Buffer contents are retained; the next accumulation uses in_first to restart.
//  sat_en/relu_en are sampled per operation (at write and at load respectively);
//   changing them mid-drain affects only later loads.
// STRUCTURE
//  Package sfu_pkg: fsm state enum {IDLE, DRAIN, DONE}; PSUM max/min constants
//   as functions of width; lane slice helper macro/function.
//  Sub-module sfu_sat_add (PSUM_BW, signed a+b with sat_en); generated COL times
//   on the write path.
//  Top: buffer regs, write logic, FSM, rd_ptr, output register + ReLU.
// TESTING
//  1 Reset/idle: assert reset mid-drain (out_valid=1) -> outputs 0 same cycle; busy=0;
//    after release, drain streams all-zero entries.
//  2 Accumulate: addr 3, first=1 psum=5 in all lanes, then +7, then -20; drain ->
//    beat 3 = -8 every lane; with relu_en=1, beat 3 = 0.
//  3 Saturation, PSUM_BW=16: 32000 + 1000 -> sat_en=1 gives 32767, sat_en=0 gives
//    -32536. -32768 + -1 with sat_en=1 gives -32768.
//  4 Backpressure: drain with out_ready toggling 1,0,0,1 -> no beat lost or
//    duplicated; data stable while stalled. DEPTH beats; out_last only on entry 15;
//    done pulses once.
//  5 Drain timing: drain at T with out_ready=1 -> out_valid at T+2. DEPTH
//    consecutive beats, then done at T+2+DEPTH.
//  6 Collisions: in_valid during drain -> dropped, err=1 and sticky. In_valid with
//    drain in IDLE at addr 0 -> beat 0 includes that write. Lane independence:
//    lane 0 overflow leaves lane 1 exact.

Source files
------------

// File: rtl/sfu_pkg.sv
// rtl/sfu_pkg.sv - shared state type and lane/limit helpers for the accumulate buffer
package sfu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } sfu_state_t;

   function automatic int psum_max(input int bw);
      return (1 << (bw - 1)) - 1;
   endfunction

   function automatic int psum_min(input int bw);
      return -(1 << (bw - 1));
   endfunction

   function automatic int lane_lsb(input int lane, input int bw);
      return lane * bw;
   endfunction

endpackage

// File: rtl/sfu_sat_add.sv
// rtl/sfu_sat_add.sv - one-lane signed adder with optional saturation
module sfu_sat_add
   import sfu_pkg::*;
#(
   parameter int PSUM_BW = 16
) (
   input  logic signed [PSUM_BW-1:0] a,
   input  logic signed [PSUM_BW-1:0] b,
   input  logic                      sat_en,
   output logic signed [PSUM_BW-1:0] sum
);

   localparam logic signed [PSUM_BW-1:0] MAX_V = PSUM_BW'(psum_max(PSUM_BW));
   localparam logic signed [PSUM_BW-1:0] MIN_V = PSUM_BW'(psum_min(PSUM_BW));

   logic signed [PSUM_BW:0] full;

   assign full = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};

   // Overflow shows up as the two top bits of the extended sum disagreeing.
   always_comb begin
      sum = full[PSUM_BW-1:0];
      if (sat_en && (full[PSUM_BW] != full[PSUM_BW-1]))
         sum = full[PSUM_BW] ? MIN_V : MAX_V;
   end

endmodule

// File: rtl/sfu_acc_buf.sv
// rtl/sfu_acc_buf.sv - multi-entry psum accumulator with in-order ReLU drain
module sfu_acc_buf
   import sfu_pkg::*;
#(
   parameter  int PSUM_BW = 16,
   parameter  int COL     = 8,
   parameter  int DEPTH   = 16,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic                   in_first,
   input  logic [AW-1:0]          in_addr,
   input  logic [COL*PSUM_BW-1:0] psum_in,
   input  logic                   sat_en,
   input  logic                   relu_en,
   input  logic                   drain,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [COL*PSUM_BW-1:0] psum_out,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int            W    = COL * PSUM_BW;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   sfu_state_t    state;
   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  cur;
   logic [W-1:0]  wr_data;
   logic [W-1:0]  rd_data;
   logic [W-1:0]  relu_data;
   logic [AW-1:0] rd_ptr;
   logic          wr_en;
   logic          load;

   assign wr_en   = in_valid && (state == IDLE);
   assign cur     = mem[in_addr];
   assign rd_data = mem[rd_ptr];

   for (genvar j = 0; j < COL; j++) begin : g_lane
      logic [PSUM_BW-1:0] sum;

      sfu_sat_add #(.PSUM_BW(PSUM_BW)) u_add (
         .a      (cur[lane_lsb(j, PSUM_BW) +: PSUM_BW]),
         .b      (psum_in[lane_lsb(j, PSUM_BW) +: PSUM_BW]),
         .sat_en (sat_en),
         .sum    (sum)
      );

      assign wr_data[lane_lsb(j, PSUM_BW) +: PSUM_BW] =
         in_first ? psum_in[lane_lsb(j, PSUM_BW) +: PSUM_BW] : sum;
      assign relu_data[lane_lsb(j, PSUM_BW) +: PSUM_BW] =
         (relu_en && rd_data[lane_lsb(j, PSUM_BW) + PSUM_BW - 1]) ?
         '0 : rd_data[lane_lsb(j, PSUM_BW) +: PSUM_BW];
   end

   // Once the final entry sits in the output register nothing more is fetched.
   assign load = (state == DRAIN) && (!out_valid || out_ready) && !(out_valid && out_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (wr_en) begin
         mem[in_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         psum_out  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (in_valid && (state != IDLE))
            err <= 1'b1;
         case (state)
            IDLE: begin
               if (drain) begin
                  state  <= DRAIN;
                  busy   <= 1'b1;
                  rd_ptr <= '0;
               end
            end
            DRAIN: begin
               if (out_valid && out_ready && out_last) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  state     <= DONE;
                  done      <= 1'b1;
               end else if (load) begin
                  out_valid <= 1'b1;
                  psum_out  <= relu_data;
                  out_last  <= (rd_ptr == LAST);
                  rd_ptr    <= rd_ptr + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
